// File: rtl/atk16_sram_pkg.sv
// Shared types and constants for the external SRAM arbiter.
//   state_t      : access sequencer states (IDLE, SETUP, ACTIVE, DONE)
//   PH_*         : boot phase encodings carried on the phase input
//   PORT_*       : requester indices used by the arbiter and sequencer
package atk16_sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACTIVE,
        DONE
    } state_t;

    localparam logic PH_COPY_IMG = 1'b0;
    localparam logic PH_RUN_IMG  = 1'b1;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter with phase-based eligibility.
//   clk, rst     : clock, synchronous active-high reset
//   phase        : PH_COPY_IMG masks the CPU port, PH_RUN_IMG enables both
//   req0, req1   : raw requests from CPU and loader ports
//   take         : sequencer is idle and accepts the current grant
//   grant_valid  : at least one eligible request is present
//   grant_port   : index of the port that wins this arbitration
module sram_rr_arb
    import atk16_sram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic phase,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic grant_valid,
    output logic grant_port
);

    logic last_grant;
    logic elig0;
    logic elig1;

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        elig0       = req0 && (phase == PH_RUN_IMG);
        elig1       = req1;
        grant_valid = elig0 || elig1;
        if (elig0 && elig1) begin
            grant_port = ~last_grant;
        end else if (elig1) begin
            grant_port = PORT_LOADER;
        end else begin
            grant_port = PORT_CPU;
        end
    end

    // Resetting to the loader makes the CPU win the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_LOADER;
        end else if (take && grant_valid) begin
            last_grant <= grant_port;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Sequencer sharing one external async SRAM between the CPU (port 0) and
// the boot loader / DMA (port 1). Owns all SRAM strobes and the data-bus
// output enable; every output is driven straight from a flop.
//   clk, rst            : clock, synchronous active-high reset
//   phase               : 0 = copy image (loader only), 1 = run image (both)
//   pN_req/we/addr/wdata: request held until pN_ack
//   pN_rdata, pN_ack    : read data (held until next read ack), 1-cycle ack
//   sram_cs_n/oe_n/we_n : active-low SRAM strobes
//   sram_addr           : SRAM word address
//   sram_dq_out/dq_oe   : write data and tristate enable for the SD bus
//   sram_dq_in          : data returned from the SD bus
module sram_arbiter
    import atk16_sram_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phase,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              sram_cs_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              cur_port;
    logic              cur_we;
    logic              take;
    logic              grant_valid;
    logic              grant_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Phase only matters while idle: a grant is taken nowhere else, so an
    // access in flight is unaffected by a phase change.
    assign take = (state == IDLE);

    sram_rr_arb u_arb (
        .clk         (clk),
        .rst         (rst),
        .phase       (phase),
        .req0        (p0_req),
        .req1        (p1_req),
        .take        (take),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (grant_port == PORT_LOADER) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_port    <= PORT_CPU;
            cur_we      <= 1'b0;
            sram_cs_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur_port   <= grant_port;
                        cur_we     <= sel_we;
                        sram_addr  <= sel_addr;
                        sram_cs_n  <= 1'b0;
                        // Reads open OE immediately; writes drive the bus
                        // instead, so OE and dq_oe are never low/high together.
                        sram_oe_n  <= sel_we;
                        sram_dq_oe <= sel_we;
                        if (sel_we) begin
                            sram_dq_out <= sel_wdata;
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    // Address and data have had one cycle of setup before WE falls.
                    sram_we_n <= ~cur_we;
                    cnt       <= CNT_INIT;
                    state     <= ACTIVE;
                end
                ACTIVE: begin
                    if (cnt == 4'd0) begin
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        if (cur_port == PORT_LOADER) begin
                            p1_ack <= 1'b1;
                            if (!cur_we) p1_rdata <= sram_dq_in;
                        end else begin
                            p0_ack <= 1'b1;
                            if (!cur_we) p0_rdata <= sram_dq_in;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // CS, address and data were held through this cycle for
                    // write hold time; release them now.
                    sram_cs_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a W=1 instance with a behavioural
// SRAM device, plus a W=3 instance used for round-robin spacing.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phase = 1'b0;

    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [17:0] p0_addr = '0, p1_addr = '0;
    logic [15:0] p0_wdata = '0, p1_wdata = '0;
    logic [15:0] p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic        sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        b0_req = 0, b1_req = 0;
    logic [15:0] b0_rdata, b1_rdata;
    logic        b0_ack, b1_ack;
    logic        b_cs_n, b_oe_n, b_we_n, b_dq_oe;
    logic [17:0] b_addr;
    logic [15:0] b_dq_out, b_dq_in;
    logic [17:0] b0_addr = 18'h00021, b1_addr = 18'h00302;

    int checks = 0;
    int failures = 0;
    int contention = 0;

    logic [15:0] sram_mem [0:1023] = '{default: 16'h0000};
    logic [15:0] ref_mem  [0:1023] = '{default: 16'h0000};
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [15:0] bd_data = '0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .phase(phase),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in)
    );

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .phase(1'b1),
        .p0_req(b0_req), .p0_we(1'b0), .p0_addr(b0_addr), .p0_wdata(16'h0000),
        .p0_rdata(b0_rdata), .p0_ack(b0_ack),
        .p1_req(b1_req), .p1_we(1'b0), .p1_addr(b1_addr), .p1_wdata(16'h0000),
        .p1_rdata(b1_rdata), .p1_ack(b1_ack),
        .sram_cs_n(b_cs_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
        .sram_addr(b_addr), .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe),
        .sram_dq_in(b_dq_in)
    );

    // Behavioural async SRAM: written while CS and WE are low, read while CS and OE are low.
    always @(posedge clk) begin
        if (bd_we) sram_mem[bd_addr] <= bd_data;
        else if (!sram_cs_n && !sram_we_n) sram_mem[sram_addr[9:0]] <= sram_dq_out;
    end
    assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 16'h0000;
    assign b_dq_in    = (!b_cs_n && !b_oe_n) ? (b_addr[15:0] ^ 16'hA5A5) : 16'h0000;

    always @(negedge clk) begin
        if ((!sram_oe_n && sram_dq_oe) || (!b_oe_n && b_dq_oe)) contention++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        p0_req = 0; p1_req = 0; b0_req = 0; b1_req = 0;
        rst = 1; step(); step(); rst = 0;
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [15:0] d);
        bd_addr = a; bd_data = d; bd_we = 1; step(); bd_we = 0;
        ref_mem[a] = d;
    endtask

    // One isolated access; observes 12 cycles and summarises the strobe activity.
    task automatic run_access(input logic port, input logic we, input logic [17:0] addr,
                              input logic [15:0] wdata, output int lat, output logic [15:0] rdata,
                              output int oe_cnt, output int we_cnt, output int dqoe_cnt,
                              output int dq_bad, output int ack_cnt);
        lat = -1; rdata = '0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0; dq_bad = 0; ack_cnt = 0;
        if (port) begin p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1; end
        else      begin p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1; end
        for (int c = 1; c <= 12; c++) begin
            step();
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (sram_dq_oe) begin
                dqoe_cnt++;
                if (sram_dq_out !== wdata) dq_bad++;
            end
            if ((port ? p1_ack : p0_ack) === 1'b1) begin
                ack_cnt++;
                if (lat < 0) begin
                    lat = c;
                    rdata = port ? p1_rdata : p0_rdata;
                    if (port) p1_req = 0; else p0_req = 0;
                end
            end
        end
        if (port) p1_req = 0; else p0_req = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sram_cs_n, sram_oe_n, sram_we_n} !== 3'b111) begin
            failures++; $display("FAIL reset_strobes: got %b expected 111", {sram_cs_n, sram_oe_n, sram_we_n});
        end
        checks++;
        if ({sram_dq_oe, p0_ack, p1_ack} !== 3'b000) begin
            failures++; $display("FAIL reset_oe_ack: got %b expected 000", {sram_dq_oe, p0_ack, p1_ack});
        end
        checks++;
        if ({p0_rdata, p1_rdata} !== 32'h0) begin
            failures++; $display("FAIL reset_rdata: got %h expected 0", {p0_rdata, p1_rdata});
        end
        checks++;
        if ({sram_addr, sram_dq_out} !== 34'h0) begin
            failures++; $display("FAIL reset_addr_dq: got %h expected 0", {sram_addr, sram_dq_out});
        end
    endtask

    task automatic test_read_latency();
        int lat, oe_c, we_c, dqoe_c, bad, acks;
        logic [15:0] rd;
        bd_write(10'h123, 16'hBEEF);
        phase = 1;
        run_access(1'b0, 1'b0, 18'h00123, 16'h0000, lat, rd, oe_c, we_c, dqoe_c, bad, acks);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL read_latency: got %0d expected 3", lat); end
        checks++;
        if (rd !== 16'hBEEF) begin failures++; $display("FAIL read_data: got %h expected beef", rd); end
        checks++;
        if (oe_c !== 2) begin failures++; $display("FAIL read_oe_cycles: got %0d expected 2", oe_c); end
        checks++;
        if ({dqoe_c, we_c, acks} !== {32'd0, 32'd0, 32'd1}) begin
            failures++; $display("FAIL read_misc: dq_oe=%0d we=%0d acks=%0d expected 0 0 1", dqoe_c, we_c, acks);
        end
    endtask

    task automatic test_copy_write();
        int lat, oe_c, we_c, dqoe_c, bad, acks;
        logic [15:0] rd;
        phase = 0;
        run_access(1'b1, 1'b1, 18'h00010, 16'h1234, lat, rd, oe_c, we_c, dqoe_c, bad, acks);
        ref_mem[10'h010] = 16'h1234;
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL write_latency: got %0d expected 3", lat); end
        checks++;
        if (we_c !== 1) begin failures++; $display("FAIL write_we_cycles: got %0d expected 1", we_c); end
        checks++;
        if (dqoe_c !== 3 || bad !== 0) begin
            failures++; $display("FAIL write_dq: dq_oe cycles=%0d bad data=%0d expected 3 0", dqoe_c, bad);
        end
        checks++;
        if (sram_mem[10'h010] !== 16'h1234) begin
            failures++; $display("FAIL write_mem: got %h expected 1234", sram_mem[10'h010]);
        end
    endtask

    task automatic test_copy_gating();
        int p0_acks = 0, p1_done = 0, waited = 0;
        logic [9:0]  a0 = 10'($urandom_range(0, 15));
        logic [9:0]  wa;
        logic [15:0] wd;
        phase = 0;
        p0_we = 0; p0_addr = {8'h0, a0}; p0_req = 1;
        wa = 10'($urandom_range(0, 15)); wd = 16'($urandom);
        p1_we = 1; p1_addr = {8'h0, wa}; p1_wdata = wd; p1_req = 1;
        for (int c = 1; c <= 60 && p1_done < 3; c++) begin
            step();
            if (p0_ack) p0_acks++;
            if (p1_ack) begin
                ref_mem[wa] = wd;
                p1_done++;
                if (p1_done < 3) begin
                    wa = 10'($urandom_range(0, 15)); wd = 16'($urandom);
                    p1_addr = {8'h0, wa}; p1_wdata = wd;
                end else begin
                    p1_req = 0;
                end
            end
        end
        p1_req = 0;
        checks++;
        if (p1_done !== 3 || p0_acks !== 0) begin
            failures++; $display("FAIL copy_gating: p1 acks=%0d p0 acks=%0d expected 3 0", p1_done, p0_acks);
        end
        phase = 1;
        while (waited < 10 && p0_ack !== 1'b1) begin step(); waited++; end
        p0_req = 0;
        checks++;
        if (p0_ack !== 1'b1) begin
            failures++; $display("FAIL copy_to_run_ack: p0 not acked within 10 cycles");
        end else begin
            checks++;
            if (p0_rdata !== ref_mem[a0]) begin
                failures++; $display("FAIL copy_to_run_data: got %h expected %h", p0_rdata, ref_mem[a0]);
            end
        end
        step();
    endtask

    task automatic test_run_round_robin();
        logic        op_we  [2];
        logic [9:0]  op_addr[2];
        logic [15:0] op_data[2];
        int n = 0, last = 0;
        logic exp_port = 0;
        do_reset();
        phase = 1;
        for (int p = 0; p < 2; p++) begin
            op_we[p] = 1'($urandom); op_addr[p] = 10'($urandom_range(0, 7)); op_data[p] = 16'($urandom);
        end
        p0_we = op_we[0]; p0_addr = {8'h0, op_addr[0]}; p0_wdata = op_data[0]; p0_req = 1;
        p1_we = op_we[1]; p1_addr = {8'h0, op_addr[1]}; p1_wdata = op_data[1]; p1_req = 1;
        for (int c = 1; c <= 200 && n < 12; c++) begin
            step();
            if (p0_ack || p1_ack) begin
                int p = p1_ack ? 1 : 0;
                checks++;
                if ((p0_ack && p1_ack) || p[0] !== exp_port || (c - last) !== (n == 0 ? 3 : 4)) begin
                    failures++;
                    $display("FAIL rr_order: ack %0d port=%0d spacing=%0d expected port=%0d spacing=%0d",
                             n, p, c - last, exp_port, (n == 0 ? 3 : 4));
                end
                if (op_we[p]) begin
                    ref_mem[op_addr[p]] = op_data[p];
                end else begin
                    checks++;
                    if ((p ? p1_rdata : p0_rdata) !== ref_mem[op_addr[p]]) begin
                        failures++;
                        $display("FAIL rr_read_data: port %0d addr %0d got %h expected %h",
                                 p, op_addr[p], (p ? p1_rdata : p0_rdata), ref_mem[op_addr[p]]);
                    end
                end
                op_we[p] = 1'($urandom); op_addr[p] = 10'($urandom_range(0, 7)); op_data[p] = 16'($urandom);
                if (p == 1) begin p1_we = op_we[1]; p1_addr = {8'h0, op_addr[1]}; p1_wdata = op_data[1]; end
                else        begin p0_we = op_we[0]; p0_addr = {8'h0, op_addr[0]}; p0_wdata = op_data[0]; end
                last = c; n++; exp_port = ~exp_port;
            end
        end
        p0_req = 0; p1_req = 0;
        checks++;
        if (n !== 12) begin failures++; $display("FAIL rr_count: got %0d acks expected 12", n); end
        step(); step();
    endtask

    task automatic test_round_robin_w3();
        int n = 0, last = 0;
        logic exp_port = 0;
        do_reset();
        b0_req = 1; b1_req = 1;
        for (int c = 1; c <= 100 && n < 6; c++) begin
            step();
            if (b0_ack || b1_ack) begin
                logic p = b1_ack;
                logic [15:0] exp_d = (p ? b1_addr[15:0] : b0_addr[15:0]) ^ 16'hA5A5;
                checks++;
                if ((b0_ack && b1_ack) || p !== exp_port || (c - last) !== (n == 0 ? 5 : 6)
                    || (p ? b1_rdata : b0_rdata) !== exp_d) begin
                    failures++;
                    $display("FAIL rr_w3: ack %0d port=%0d spacing=%0d data=%h expected port=%0d spacing=%0d data=%h",
                             n, p, c - last, (p ? b1_rdata : b0_rdata), exp_port, (n == 0 ? 5 : 6), exp_d);
                end
                last = c; n++; exp_port = ~exp_port;
            end
        end
        b0_req = 0; b1_req = 0;
        checks++;
        if (n !== 6) begin failures++; $display("FAIL rr_w3_count: got %0d acks expected 6", n); end
        step(); step();
    endtask

    task automatic test_reset_mid_write();
        int lat, oe_c, we_c, dqoe_c, bad, acks, stray = 0;
        logic [15:0] rd;
        phase = 1;
        p0_we = 1; p0_addr = 18'h00040; p0_wdata = 16'($urandom); p0_req = 1;
        step(); step();
        checks++;
        if (sram_we_n !== 1'b0) begin failures++; $display("FAIL abort_setup: we_n=%b expected 0 in ACTIVE", sram_we_n); end
        rst = 1;
        step();
        rst = 0; p0_req = 0;
        checks++;
        if ({sram_we_n, sram_cs_n, sram_oe_n, sram_dq_oe, p0_ack} !== 5'b11100) begin
            failures++;
            $display("FAIL abort_strobes: we,cs,oe,dq_oe,ack=%b expected 11100",
                     {sram_we_n, sram_cs_n, sram_oe_n, sram_dq_oe, p0_ack});
        end
        for (int c = 0; c < 5; c++) begin step(); if (p0_ack || p1_ack) stray++; end
        checks++;
        if (stray !== 0) begin failures++; $display("FAIL abort_no_ack: got %0d acks expected 0", stray); end
        run_access(1'b0, 1'b0, 18'h00123, 16'h0000, lat, rd, oe_c, we_c, dqoe_c, bad, acks);
        checks++;
        if (lat !== 3 || rd !== ref_mem[10'h123]) begin
            failures++; $display("FAIL abort_next_read: latency=%0d data=%h expected 3 %h", lat, rd, ref_mem[10'h123]);
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_copy_write();
        test_copy_gating();
        test_run_round_robin();
        test_round_robin_w3();
        test_reset_mid_write();
        checks++;
        if (contention !== 0) begin
            failures++; $display("FAIL bus_contention: got %0d cycles expected 0", contention);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
